// File: rtl/reset_sequencer.sv
// Staged reset release: holds every subsystem in reset, then frees them one at a
// time in index order, each gated on its ready acknowledge or a per-stage timeout.
module reset_sequencer #(
   parameter int STAGES      = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_reset,
   input  logic [STAGES-1:0]         stage_ready,
   output logic [STAGES-1:0]         stage_reset,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout_err,
   output logic [$clog2(STAGES)-1:0] err_stage
);
   localparam int IW = $clog2(STAGES);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST      = IW'(STAGES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_HOLD, S_WAIT, S_DONE} state_t;

   state_t            state, state_n;
   logic [IW-1:0]     idx, idx_n;
   logic [HW-1:0]     hold_cnt, hold_n;
   logic [WW-1:0]     wait_cnt, wait_n;
   logic [STAGES-1:0] sreset_n;
   logic              busy_n, done_n, terr_n;
   logic [IW-1:0]     estage_n;
   logic              ready_i, expire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_HOLD;
         idx         <= '0;
         hold_cnt    <= '0;
         wait_cnt    <= '0;
         stage_reset <= '1;
         busy        <= 1'b1;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         err_stage   <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         hold_cnt    <= hold_n;
         wait_cnt    <= wait_n;
         stage_reset <= sreset_n;
         busy        <= busy_n;
         done        <= done_n;
         timeout_err <= terr_n;
         err_stage   <= estage_n;
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      hold_n   = hold_cnt;
      wait_n   = wait_cnt;
      sreset_n = stage_reset;
      busy_n   = busy;
      done_n   = done;
      terr_n   = timeout_err;
      estage_n = err_stage;
      ready_i  = stage_ready[idx];
      expire   = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

      if (req_reset) begin
         state_n  = S_HOLD;
         idx_n    = '0;
         hold_n   = '0;
         wait_n   = '0;
         sreset_n = '1;
         busy_n   = 1'b1;
         done_n   = 1'b0;
         terr_n   = 1'b0;
         estage_n = '0;
      end else begin
         case (state)
            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_n      = '0;
                  idx_n       = '0;
                  sreset_n[0] = 1'b0;
                  state_n     = S_WAIT;
               end else begin
                  hold_n = hold_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               // A ready that coincides with expiry wins, so no error is flagged.
               if (ready_i || expire) begin
                  wait_n = '0;
                  if (!ready_i) begin
                     terr_n = 1'b1;
                     if (!timeout_err) estage_n = idx;
                  end
                  if (idx == LAST) begin
                     state_n = S_DONE;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     idx_n                 = idx + 1'b1;
                     sreset_n[idx + 1'b1]  = 1'b0;
                  end
               end else if (wait_cnt != '1) begin
                  wait_n = wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: one build with TIMEOUT=8 and one with TIMEOUT=0 share
// stimulus; an integer-level model is compared every cycle, plus literal spot checks.
module tb_reset_sequencer;
   localparam int S = 3;
   localparam int H = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          req_reset = 1'b0;
   logic [S-1:0]  stage_ready = '1;
   logic [S-1:0]  sr_a, sr_b;
   logic          busy_a, busy_b, done_a, done_b, terr_a, terr_b;
   logic [1:0]    es_a, es_b;

   reset_sequencer #(.STAGES(S), .HOLD_CYCLES(H), .TIMEOUT(8)) u_dut (
      .clk(clk), .reset(reset), .req_reset(req_reset), .stage_ready(stage_ready),
      .stage_reset(sr_a), .busy(busy_a), .done(done_a), .timeout_err(terr_a), .err_stage(es_a)
   );

   reset_sequencer #(.STAGES(S), .HOLD_CYCLES(H), .TIMEOUT(0)) u_dut_nto (
      .clk(clk), .reset(reset), .req_reset(req_reset), .stage_ready(stage_ready),
      .stage_reset(sr_b), .busy(busy_b), .done(done_b), .timeout_err(terr_b), .err_stage(es_b)
   );

   int checks = 0;
   int errors = 0;

   // Model: pos = -1 while holding, k while waiting on stage k, S when finished.
   int m_pos[2];
   int m_cnt[2];
   int m_es[2];
   bit m_err[2];
   bit started = 1'b0;

   function automatic int tmo(int d);
      return (d == 0) ? 8 : 0;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset || req_reset) begin
            m_pos[d] = -1; m_cnt[d] = 0; m_err[d] = 1'b0; m_es[d] = 0;
         end else if (m_pos[d] < 0) begin
            m_cnt[d]++;
            if (m_cnt[d] == H) begin m_pos[d] = 0; m_cnt[d] = 0; end
         end else if (m_pos[d] < S) begin
            m_cnt[d]++;
            if (stage_ready[m_pos[d]]) begin
               m_pos[d]++; m_cnt[d] = 0;
            end else if (tmo(d) != 0 && m_cnt[d] == tmo(d)) begin
               if (!m_err[d]) m_es[d] = m_pos[d];
               m_err[d] = 1'b1;
               m_pos[d]++; m_cnt[d] = 0;
            end
         end
      end
      if (reset) started = 1'b1;
   end

   function automatic logic [S-1:0] exp_sr(int d);
      logic [S-1:0] r;
      for (int k = 0; k < S; k++) r[k] = (m_pos[d] < k);
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (started) begin
         chk("a.stage_reset", 32'(sr_a),   32'(exp_sr(0)));
         chk("a.busy",        32'(busy_a), 32'(m_pos[0] < S));
         chk("a.done",        32'(done_a), 32'(m_pos[0] == S));
         chk("a.timeout_err", 32'(terr_a), 32'(m_err[0]));
         chk("a.err_stage",   32'(es_a),   32'(m_es[0]));
         chk("b.stage_reset", 32'(sr_b),   32'(exp_sr(1)));
         chk("b.busy",        32'(busy_b), 32'(m_pos[1] < S));
         chk("b.done",        32'(done_b), 32'(m_pos[1] == S));
         chk("b.timeout_err", 32'(terr_b), 32'(m_err[1]));
         chk("b.err_stage",   32'(es_b),   32'(m_es[1]));
      end
   endtask

   task automatic cycn(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic lit(string nm, int d, logic [2:0] sr, logic b, logic dn, logic te, logic [1:0] es);
      if (d == 0) begin
         chk({nm, ".sr"},   32'(sr_a),   32'(sr));
         chk({nm, ".busy"}, 32'(busy_a), 32'(b));
         chk({nm, ".done"}, 32'(done_a), 32'(dn));
         chk({nm, ".terr"}, 32'(terr_a), 32'(te));
         chk({nm, ".es"},   32'(es_a),   32'(es));
      end else begin
         chk({nm, ".sr"},   32'(sr_b),   32'(sr));
         chk({nm, ".busy"}, 32'(busy_b), 32'(b));
         chk({nm, ".done"}, 32'(done_b), 32'(dn));
         chk({nm, ".terr"}, 32'(terr_b), 32'(te));
         chk({nm, ".es"},   32'(es_b),   32'(es));
      end
   endtask

   task automatic soft_req(logic [2:0] rdy);
      stage_ready = rdy;
      req_reset = 1'b1;
      cyc();
      req_reset = 1'b0;
   endtask

   initial begin
      // Power-on
      cycn(3);           lit("por.reset", 0, 3'b111, 1, 0, 0, 0);
      reset = 1'b0;
      cycn(3);           lit("por.e3", 0, 3'b111, 1, 0, 0, 0);
      cyc();             lit("por.e4", 0, 3'b110, 1, 0, 0, 0);
      cyc();             lit("por.e5", 0, 3'b100, 1, 0, 0, 0);
      cyc();             lit("por.e6", 0, 3'b000, 1, 0, 0, 0);
      cyc();             lit("por.e7", 0, 3'b000, 0, 1, 0, 0);
      stage_ready = 3'b110;
      cycn(3);           lit("stale.done", 0, 3'b000, 0, 1, 0, 0);

      // Delayed ack of stage 1, stage 2 ready early and ignored
      soft_req(3'b101);  lit("dly.req", 0, 3'b111, 1, 0, 0, 0);
      cycn(4);           lit("dly.hold", 0, 3'b110, 1, 0, 0, 0);
      cyc();             lit("dly.w1", 0, 3'b100, 1, 0, 0, 0);
      cycn(4);           lit("dly.w1_4", 0, 3'b100, 1, 0, 0, 0);
      stage_ready = 3'b111;
      cyc();             lit("dly.ack1", 0, 3'b000, 1, 0, 0, 0);
      cyc();             lit("dly.done", 0, 3'b000, 0, 1, 0, 0);

      // Stage 0 times out
      soft_req(3'b110);
      cycn(4);           lit("to.hold", 0, 3'b110, 1, 0, 0, 0);
      cycn(7);           lit("to.w7", 0, 3'b110, 1, 0, 0, 0);
      cyc();             lit("to.e8", 0, 3'b100, 1, 0, 1, 0);
      cycn(2);           lit("to.done", 0, 3'b000, 0, 1, 1, 0);

      // Stages 0 and 2 time out: first index sticks
      soft_req(3'b010);
      cycn(4 + 8);       lit("to2.s0", 0, 3'b100, 1, 0, 1, 0);
      cyc();             lit("to2.s1", 0, 3'b000, 1, 0, 1, 0);
      cycn(8);           lit("to2.done", 0, 3'b000, 0, 1, 1, 0);

      // Only stage 2 times out
      soft_req(3'b011);
      cycn(4 + 2 + 7);   lit("to3.w7", 0, 3'b000, 1, 0, 0, 0);
      cyc();             lit("to3.done", 0, 3'b000, 0, 1, 1, 2);

      // reset and req_reset together
      reset = 1'b1; req_reset = 1'b1;
      cyc();             lit("prio.a", 0, 3'b111, 1, 0, 0, 0);
                         lit("prio.b", 1, 3'b111, 1, 0, 0, 0);
      reset = 1'b0; req_reset = 1'b0; stage_ready = 3'b111;
      cycn(4);           lit("prio.hold", 0, 3'b110, 1, 0, 0, 0);

      // Ready and expiry on the same edge
      soft_req(3'b110);
      cycn(4 + 7);       lit("sim.w7", 0, 3'b110, 1, 0, 0, 0);
      stage_ready = 3'b111;
      cyc();             lit("sim.e8", 0, 3'b100, 1, 0, 0, 0);
      cycn(2);           lit("sim.done", 0, 3'b000, 0, 1, 0, 0);

      // Soft reset while waiting on stage 1
      soft_req(3'b001);
      cycn(4 + 2);       lit("mid.w1", 0, 3'b100, 1, 0, 0, 0);
      req_reset = 1'b1;
      cyc();             lit("mid.req", 0, 3'b111, 1, 0, 0, 0);
      req_reset = 1'b0; stage_ready = 3'b111;
      cycn(3);           lit("mid.h3", 0, 3'b111, 1, 0, 0, 0);
      cyc();             lit("mid.h4", 0, 3'b110, 1, 0, 0, 0);

      // Held request keeps restarting the hold
      req_reset = 1'b1;
      cycn(3);           lit("held.req", 0, 3'b111, 1, 0, 0, 0);
      req_reset = 1'b0;
      cycn(3);           lit("held.h3", 0, 3'b111, 1, 0, 0, 0);
      cyc();             lit("held.h4", 0, 3'b110, 1, 0, 0, 0);
      cycn(3);           lit("held.done", 0, 3'b000, 0, 1, 0, 0);

      // Stage 1 never ready: no-timeout build waits indefinitely
      soft_req(3'b101);
      cycn(5);           lit("nto.w1", 1, 3'b100, 1, 0, 0, 0);
      cycn(2000);        lit("nto.b", 1, 3'b100, 1, 0, 0, 0);
                         lit("nto.a", 0, 3'b000, 0, 1, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
